// File: rtl/mc_pkg.sv
// Shared encodings and control-word decode for the multi-cycle MIPS sequencer.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LOAD_WB  = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10
    } mcState_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b000101;
    localparam logic [5:0] OP_BEQ   = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b000111;

    localparam logic [2:0] ALUOP_FUNCT = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_IMM   = 3'b010;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic       pcSource;
    } mcCtrl_t;

    // Moore control word for a state; pcWrite/irWrite are still ungated by mem_ready here.
    function automatic mcCtrl_t decodeCtrl(input mcState_e st, input logic [5:0] op);
        mcCtrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.memRead = 1'b1;
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
                c.aluSrcB = SRCB_FOUR;
                c.aluOp   = ALUOP_ADD;
            end
            S_DECODE: begin
                c.aluSrcB = SRCB_IMM_SH2;
                c.aluOp   = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            S_LOAD_WB: begin
                c.regWrite = 1'b1;
                c.memtoReg = 1'b1;
            end
            S_MEM_WR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            S_R_EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_REG;
                c.aluOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
            end
            S_I_EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
            end
            S_I_WB: begin
                c.regWrite = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluSrcB     = SRCB_REG;
                c.aluOp       = ALUOP_SUB;
                c.pcWriteCond = 1'b1;
                c.pcSource    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic isMemState(input mcState_e st);
        return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_controller_perf_counters.sv
// Cycle / retired-instruction / memory-stall counters for the multi-cycle sequencer.
module mc_perf_counters
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  mcState_e         curState,
    input  logic             memReady,
    output logic [CNT_W-1:0] cycleCount,
    output logic [CNT_W-1:0] instrCount,
    output logic [CNT_W-1:0] stallCount
);

    logic retire;
    logic stall;

    // Retirement is the step that returns the sequencer to FETCH.
    assign retire = (curState == S_LOAD_WB) || (curState == S_R_WB) ||
                    (curState == S_I_WB) || (curState == S_BRANCH) ||
                    ((curState == S_MEM_WR) && memReady);
    assign stall  = isMemState(curState) && !memReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount <= '0;
            instrCount <= '0;
            stallCount <= '0;
        end else begin
            cycleCount <= cycleCount + CNT_W'(1);
            if (retire) begin
                instrCount <= instrCount + CNT_W'(1);
            end
            if (stall) begin
                stallCount <= stallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM sharing one ALU and one memory port.
// Optional perf counters are built when MC_PERF_COUNTERS_EN is defined.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCEn,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               PCSource,
    output logic [STATE_W-1:0] state
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count,
    output logic [CNT_W-1:0]   stall_count
`endif
);

    if (STATE_W < 4) begin : gStateWidthCheck
        $error("STATE_W must be at least 4");
    end
    if (CNT_W < 1) begin : gCntWidthCheck
        $error("CNT_W must be at least 1");
    end

    mcState_e stateQ;
    mcState_e nextState;
    mcCtrl_t  ctrlQ;

    always_comb begin
        nextState = S_FETCH;
        case (stateQ)
            S_FETCH:    nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    nextState = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    nextState = S_R_EXEC;
                end else if (opcode == OP_BEQ) begin
                    nextState = S_BRANCH;
                end else begin
                    nextState = S_I_EXEC;
                end
            end
            S_MEM_ADDR: nextState = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   nextState = mem_ready ? S_LOAD_WB : S_MEM_RD;
            S_MEM_WR:   nextState = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   nextState = S_R_WB;
            S_I_EXEC:   nextState = S_I_WB;
            default:    nextState = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state, decoded from the state being entered.
    // opcode is stable from DECODE onward, so the I_EXEC ALUOp is valid at that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= S_FETCH;
            ctrlQ  <= decodeCtrl(S_FETCH, opcode);
        end else begin
            stateQ <= nextState;
            ctrlQ  <= decodeCtrl(nextState, opcode);
        end
    end

    // Reset masks every strobe combinationally so an abandoned access drops immediately.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 1'b0;
        state       = '0;
        if (!reset) begin
            PCWrite     = ctrlQ.pcWrite & mem_ready;
            PCWriteCond = ctrlQ.pcWriteCond;
            IorD        = ctrlQ.iorD;
            IRWrite     = ctrlQ.irWrite & mem_ready;
            MemRead     = ctrlQ.memRead;
            MemWrite    = ctrlQ.memWrite;
            RegDst      = ctrlQ.regDst;
            MemtoReg    = ctrlQ.memtoReg;
            RegWrite    = ctrlQ.regWrite;
            ALUSrcA     = ctrlQ.aluSrcA;
            ALUSrcB     = ctrlQ.aluSrcB;
            ALUOp       = ctrlQ.aluOp;
            PCSource    = ctrlQ.pcSource;
            state       = STATE_W'(stateQ);
        end
        PCEn = PCWrite | (PCWriteCond & zero);
    end

`ifdef MC_PERF_COUNTERS_EN
    mc_perf_counters #(
        .CNT_W(CNT_W)
    ) uPerf (
        .clk       (clk),
        .reset     (reset),
        .curState  (stateQ),
        .memReady  (mem_ready),
        .cycleCount(cycle_count),
        .instrCount(instr_count),
        .stallCount(stall_count)
    );
`endif

endmodule
